// File: rtl/ast_we_arb_pkg.sv
// ast_we_arb_pkg: shared types and round-robin helpers for the packet arbiter.
package ast_we_arb_pkg;
    localparam int MAX_SRC = 16;
    localparam int MAX_IDX_W = 4;
    typedef enum logic {IDLE, PKT} state_t;
    typedef struct packed {
        logic                 found;
        logic [MAX_IDX_W-1:0] idx;
    } pick_t;
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
    // Scans ptr, ptr+1, ... mod n; walking backwards lets the earliest hit win.
    function automatic pick_t rr_next(input int n, input logic [MAX_IDX_W-1:0] ptr, input logic [MAX_SRC-1:0] req);
        pick_t r;
        int j;
        r = '0;
        for (int k = MAX_SRC - 1; k >= 0; k--) begin
            j = (int'(ptr) + k) % n;
            if (k < n && req[j]) begin
                r.found = 1'b1;
                r.idx = MAX_IDX_W'(j);
            end
        end
        return r;
    endfunction
endpackage

// File: rtl/ast_we_packet_arbiter_if.sv
// ast_we_packet_arbiter_if: per-source Avalon-ST sinks plus the shared source toward the width extender.
interface ast_we_packet_arbiter_if #(
    parameter int NUM_SRC = 4,
    parameter int DATA_W = 32,
    parameter int EMPTY_W = 2,
    parameter int CHANNEL_W = 4
);
    logic [NUM_SRC*DATA_W-1:0]  snk_data;
    logic [NUM_SRC*EMPTY_W-1:0] snk_empty;
    logic [NUM_SRC-1:0]         snk_startofpacket;
    logic [NUM_SRC-1:0]         snk_endofpacket;
    logic [NUM_SRC-1:0]         snk_valid;
    logic [NUM_SRC-1:0]         snk_ready;
    logic [DATA_W-1:0]          src_data;
    logic [EMPTY_W-1:0]         src_empty;
    logic                       src_startofpacket;
    logic                       src_endofpacket;
    logic [CHANNEL_W-1:0]       src_channel;
    logic                       src_valid;
    logic                       src_ready;
    modport master (
        output snk_data, snk_empty, snk_startofpacket, snk_endofpacket, snk_valid, src_ready,
        input  snk_ready, src_data, src_empty, src_startofpacket, src_endofpacket, src_channel, src_valid
    );
    modport slave (
        input  snk_data, snk_empty, snk_startofpacket, snk_endofpacket, snk_valid, src_ready,
        output snk_ready, src_data, src_empty, src_startofpacket, src_endofpacket, src_channel, src_valid
    );
endinterface

// File: rtl/ast_rr_picker.sv
// ast_rr_picker: combinational round-robin pick of the first request at or after ptr.
module ast_rr_picker import ast_we_arb_pkg::*; #(
    parameter int NUM_SRC = 4,
    localparam int IDX_W = idx_w(NUM_SRC)
) (
    input  logic [NUM_SRC-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic               found,
    output logic [IDX_W-1:0]   idx
);
    pick_t p;
    assign p = rr_next(NUM_SRC, MAX_IDX_W'(ptr), MAX_SRC'(req));
    assign found = p.found;
    assign idx = IDX_W'(p.idx);
endmodule

// File: rtl/ast_we_packet_arbiter.sv
// ast_we_packet_arbiter: packet-locked round-robin arbiter feeding one Avalon-ST width extender,
// dropping orphan beats so framing errors upstream cannot stall the shared sink.
module ast_we_packet_arbiter import ast_we_arb_pkg::*; #(
    parameter int NUM_SRC = 4,
    parameter int DATA_W = 32,
    parameter int EMPTY_W = 2,
    parameter int CHANNEL_W = 4,
    localparam int IDX_W = idx_w(NUM_SRC)
) (
    input  logic               clk,
    input  logic               arst_n,
    input  logic [NUM_SRC-1:0] src_en,
    ast_we_packet_arbiter_if.slave bus,
    output logic [IDX_W-1:0]   grant_idx,
    output logic               busy,
    output logic               err_orphan
);
    state_t state, state_nxt;
    logic [IDX_W-1:0] rr_ptr, pick_idx, orph_idx;
    logic found, load, acc, eop, orph_hit;
    logic [NUM_SRC-1:0] cand, orph, ready;

    assign cand = src_en & bus.snk_valid & bus.snk_startofpacket;
    assign orph = bus.snk_valid & ~bus.snk_startofpacket;
    assign orph_hit = |orph;
    assign load = !bus.src_valid || bus.src_ready;
    assign acc = state == PKT && bus.snk_valid[grant_idx] && load;
    assign eop = bus.snk_endofpacket[grant_idx];
    assign bus.snk_ready = ready;

    ast_rr_picker #(.NUM_SRC(NUM_SRC)) u_pick (
        .req(cand),
        .ptr(rr_ptr),
        .found(found),
        .idx(pick_idx)
    );

    always_comb begin
        orph_idx = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) if (orph[i]) orph_idx = IDX_W'(i);
    end

    always_ff @(posedge clk or negedge arst_n)
        if (!arst_n) state <= IDLE;
        else state <= state_nxt;

    always_comb
        state_nxt = (state == IDLE) ? (found ? PKT : IDLE) : ((acc && eop) ? IDLE : PKT);

    // Orphans are only swept between packets, so a granted packet is never starved by them.
    always_comb begin
        ready = '0;
        if (arst_n && state == IDLE && orph_hit) ready[orph_idx] = 1'b1;
        if (arst_n && state == PKT) ready[grant_idx] = load;
        err_orphan = arst_n && state == IDLE && orph_hit;
        busy = state == PKT;
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            grant_idx <= '0;
            rr_ptr <= '0;
        end else begin
            if (state == IDLE && found) grant_idx <= pick_idx;
            if (acc && eop) rr_ptr <= (grant_idx == IDX_W'(NUM_SRC - 1)) ? '0 : grant_idx + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            bus.src_valid <= 1'b0;
            bus.src_data <= '0;
            bus.src_empty <= '0;
            bus.src_startofpacket <= 1'b0;
            bus.src_endofpacket <= 1'b0;
            bus.src_channel <= '0;
        end else if (load) begin
            bus.src_valid <= acc;
            if (acc) begin
                bus.src_data <= bus.snk_data[grant_idx*DATA_W +: DATA_W];
                bus.src_empty <= bus.snk_empty[grant_idx*EMPTY_W +: EMPTY_W];
                bus.src_startofpacket <= bus.snk_startofpacket[grant_idx];
                bus.src_endofpacket <= eop;
                bus.src_channel <= CHANNEL_W'(grant_idx);
            end
        end
    end
endmodule

// File: tb/tb_ast_we_packet_arbiter.sv
// tb_ast_we_packet_arbiter: directed packets per source with a scoreboard of expected output beats.
module tb_ast_we_packet_arbiter;
    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  empty;
        logic        sop;
        logic        eop;
        logic [3:0]  ch;
    } beat_t;

    logic clk = 1'b0;
    logic arst_n = 1'b0;
    logic [3:0] src_en = 4'b1111;
    logic [1:0] grant_idx;
    logic busy, err_orphan;

    ast_we_packet_arbiter_if bus();

    ast_we_packet_arbiter dut (
        .clk(clk),
        .arst_n(arst_n),
        .src_en(src_en),
        .bus(bus),
        .grant_idx(grant_idx),
        .busy(busy),
        .err_orphan(err_orphan)
    );

    always #5 clk = ~clk;

    beat_t srcq[4][$];
    beat_t expq[$];
    int checks = 0;
    int errors = 0;
    int orph_cnt = 0;
    bit mon_en = 1'b1;
    bit toggle = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h", name, act, exp);
        end
    endtask

    task automatic mk_pkt(input int s, input int id, input int n, input logic [1:0] le, input bit to_src, input bit to_exp);
        beat_t b;
        for (int k = 0; k < n; k++) begin
            b.data = {8'(s), 8'(id), 16'(k)};
            b.sop = (k == 0);
            b.eop = (k == n - 1);
            b.empty = b.eop ? le : 2'd0;
            b.ch = 4'(s);
            if (to_src) srcq[s].push_back(b);
            if (to_exp) expq.push_back(b);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_snk_ready"}, 64'(bus.snk_ready), 0);
        chk({tag, "_src_valid"}, 64'(bus.src_valid), 0);
        chk({tag, "_src_data"}, 64'(bus.src_data), 0);
        chk({tag, "_src_empty"}, 64'(bus.src_empty), 0);
        chk({tag, "_src_sop"}, 64'(bus.src_startofpacket), 0);
        chk({tag, "_src_eop"}, 64'(bus.src_endofpacket), 0);
        chk({tag, "_src_channel"}, 64'(bus.src_channel), 0);
        chk({tag, "_grant_idx"}, 64'(grant_idx), 0);
        chk({tag, "_busy"}, 64'(busy), 0);
        chk({tag, "_err_orphan"}, 64'(err_orphan), 0);
    endtask

    task automatic do_reset(input string tag);
        @(posedge clk);
        #2 arst_n = 1'b0;
        #1 chk_zero(tag);
        repeat (2) @(posedge clk);
        #3 arst_n = 1'b1;
        @(posedge clk);
        #2;
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while (expq.size() != 0 && n < 2000) begin
            @(posedge clk);
            n++;
        end
        if (expq.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout act=%0d exp=0 beats outstanding", tag, expq.size());
            expq.delete();
        end
        repeat (4) @(posedge clk);
        #2;
    endtask

    // Avalon-ST sources: each presents the head of its queue and pops it once handshaken.
    initial begin
        logic [3:0] fire;
        int cyc;
        cyc = 0;
        bus.snk_data = '0;
        bus.snk_empty = '0;
        bus.snk_startofpacket = '0;
        bus.snk_endofpacket = '0;
        bus.snk_valid = '0;
        bus.src_ready = 1'b1;
        forever begin
            @(negedge clk);
            fire = bus.snk_valid & bus.snk_ready;
            @(posedge clk);
            #1;
            for (int i = 0; i < 4; i++) begin
                if (fire[i] && srcq[i].size() > 0) void'(srcq[i].pop_front());
                if (srcq[i].size() > 0) begin
                    bus.snk_data[i*32 +: 32] = srcq[i][0].data;
                    bus.snk_empty[i*2 +: 2] = srcq[i][0].empty;
                    bus.snk_startofpacket[i] = srcq[i][0].sop;
                    bus.snk_endofpacket[i] = srcq[i][0].eop;
                    bus.snk_valid[i] = 1'b1;
                end else begin
                    bus.snk_valid[i] = 1'b0;
                end
            end
            bus.src_ready = toggle ? (cyc % 4 == 0 || cyc % 4 == 3) : 1'b1;
            cyc++;
        end
    end

    initial begin
        beat_t e, a;
        forever begin
            @(negedge clk);
            if (mon_en && arst_n) begin
                if (err_orphan) orph_cnt++;
                if (bus.src_valid && bus.src_ready) begin
                    if (expq.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_beat act=%0h exp=none", bus.src_data);
                    end else begin
                        e = expq.pop_front();
                        a = {bus.src_data, bus.src_empty, bus.src_startofpacket, bus.src_endofpacket, bus.src_channel};
                        chk("out_beat", 64'(a), 64'(e));
                    end
                end
            end
        end
    end

    initial begin
        int n;
        beat_t o;
        do_reset("rst0");
        // Sources 0 and 2 at once: 0 wins, then 2, leaving rr_ptr at 3.
        mk_pkt(0, 1, 3, 2'd1, 1, 1);
        mk_pkt(2, 1, 3, 2'd3, 1, 1);
        drain("t1");
        mk_pkt(0, 2, 1, 2'd0, 1, 0);
        mk_pkt(3, 2, 1, 2'd0, 1, 0);
        mk_pkt(3, 2, 1, 2'd0, 0, 1);
        mk_pkt(0, 2, 1, 2'd0, 0, 1);
        drain("t1_ptr");
        // Twelve single-beat packets rotate 0,1,2,3,...
        do_reset("rst1");
        for (int r = 0; r < 3; r++)
            for (int s = 0; s < 4; s++) mk_pkt(s, 10 + r, 1, 2'(s), 1, 1);
        drain("t2");
        toggle = 1'b1;
        mk_pkt(1, 20, 4, 2'd2, 1, 1);
        drain("t3");
        toggle = 1'b0;
        // Orphan alone, then an orphan alongside a legitimate pick.
        orph_cnt = 0;
        o = '{data: 32'hDEAD0003, empty: 2'd0, sop: 1'b0, eop: 1'b1, ch: 4'd3};
        srcq[3].push_back(o);
        drain("t4");
        chk("t4_orphan_pulses", 64'(orph_cnt), 1);
        chk("t4_orphan_consumed", 64'(srcq[3].size()), 0);
        orph_cnt = 0;
        srcq[3].push_back(o);
        mk_pkt(1, 30, 2, 2'd1, 1, 1);
        drain("t4b");
        chk("t4b_orphan_pulses", 64'(orph_cnt), 1);
        // Disabled source 2 waits; clearing src_en[1] mid-packet must not cut it short.
        src_en = 4'b1011;
        mk_pkt(2, 40, 3, 2'd0, 1, 0);
        mk_pkt(1, 40, 4, 2'd1, 1, 1);
        n = 0;
        while (!busy && n < 50) begin
            @(posedge clk);
            #2;
            n++;
        end
        chk("t5_busy", 64'(busy), 1);
        @(posedge clk);
        #2 src_en = 4'b1001;
        drain("t5");
        chk("t5_src2_pending", 64'(srcq[2].size()), 3);
        chk("t5_grant", 64'(grant_idx), 1);
        chk("t5_idle", 64'(busy), 0);
        src_en = 4'b1111;
        mk_pkt(2, 40, 3, 2'd0, 0, 1);
        drain("t5b");
        chk("t5_src2_done", 64'(srcq[2].size()), 0);
        // Reset during beat 2 of a 5-beat packet, then rr_ptr must restart at 0.
        do_reset("rst2");
        mk_pkt(2, 50, 1, 2'd0, 1, 1);
        drain("t6a");
        mon_en = 1'b0;
        mk_pkt(3, 51, 5, 2'd0, 1, 0);
        n = 0;
        while (srcq[3].size() != 4 && n < 50) begin
            @(posedge clk);
            #2;
            n++;
        end
        chk("t6_at_beat2", 64'(srcq[3].size()), 4);
        arst_n = 1'b0;
        #1 chk_zero("t6_rst");
        for (int i = 0; i < 4; i++) srcq[i].delete();
        repeat (2) @(posedge clk);
        #3 arst_n = 1'b1;
        mon_en = 1'b1;
        @(posedge clk);
        #2;
        mk_pkt(3, 52, 1, 2'd0, 1, 0);
        mk_pkt(1, 52, 1, 2'd0, 1, 0);
        mk_pkt(1, 52, 1, 2'd0, 0, 1);
        mk_pkt(3, 52, 1, 2'd0, 0, 1);
        drain("t6b");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/ast_we_packet_arbiter.md
Name: ast_we_packet_arbiter

Overview:
Packet-level round-robin arbiter that shares one Avalon-ST width-extender sink among NUM_SRC upstream packet sources. It locks the grant from SOP to EOP so packets never interleave. It tags each output beat's channel with the granted source index. It drops orphan beats (valid without a preceding SOP) and flags them, so upstream framing errors cannot deadlock the extender.

Parameters:
NUM_SRC, 4, number of requesting sources (2..16)
DATA_W, 32, beat data width (equals the extender's DATA_IN_W)
EMPTY_W, 2, empty field width (equals the extender's EMPTY_IN_W)
CHANNEL_W, 4, output channel width; must be >= $clog2(NUM_SRC); source index is zero-extended

Ports:
clk  in  1  single clock
arst_n  in  1  asynchronous active-low reset
src_en  in  NUM_SRC  per-source enable mask, sampled only in IDLE
snk_data  in  NUM_SRC*DATA_W  per-source data, source i at [i*DATA_W +: DATA_W]
snk_empty  in  NUM_SRC*EMPTY_W  per-source empty
snk_startofpacket  in  NUM_SRC  per-source SOP
snk_endofpacket  in  NUM_SRC  per-source EOP
snk_valid  in  NUM_SRC  per-source valid
snk_ready  out  NUM_SRC  per-source ready
src_data  out  DATA_W  to extender snk_data
src_empty  out  EMPTY_W  to extender snk_empty
src_startofpacket  out  1  to extender
src_endofpacket  out  1  to extender
src_channel  out  CHANNEL_W  granted source index
src_valid  out  1  to extender
src_ready  in  1  from extender snk_ready
grant_idx  out  $clog2(NUM_SRC)  current or last grant
busy  out  1  high in PKT state
err_orphan  out  1  one-cycle pulse per dropped orphan beat

Behaviour:
- Reset (async assert, sync release) forces: state IDLE; src_valid 0; src_data, src_empty, src_sop, src_eop, src_channel 0; snk_ready all 0; grant_idx 0; rr_ptr 0 (source 0 has top priority); busy 0; err_orphan 0.
- Output stage: one register slice. load = !src_valid || src_ready. Each accepted input beat appears at src_* on the next cycle. Throughput is 1 beat/cycle while src_ready stays high.
- IDLE:
  - Candidate i = src_en[i] && snk_valid[i] && snk_sop[i].
  - Pick the first candidate scanning rr_ptr, rr_ptr+1, ... with wrap modulo NUM_SRC.
  - On a pick: register grant_idx, go to PKT. No beat is accepted in this cycle, so there is exactly one arbitration bubble per packet.
  - Orphan handling in the same cycle: the lowest-index source with snk_valid && !snk_sop (enabled or not) gets snk_ready=1. Its beat is discarded and err_orphan pulses. Only one orphan is dropped per cycle. Orphan dropping and a pick may occur in the same cycle on different sources.
- PKT:
  - snk_ready[grant_idx] = load; all other snk_ready are 0.
  - An accepted beat (valid && ready) is copied to the output stage, with src_channel = grant_idx.
  - A further SOP inside the packet is passed through unchanged; no correction is made.
  - On an accepted beat with EOP: go to IDLE and set rr_ptr = grant_idx+1, wrapping NUM_SRC-1 -> 0.
  - A single-beat packet (SOP and EOP together) gives PKT for one accept and then IDLE.
- Clearing src_en mid-packet does not abort the packet; it only blocks future picks.
- Output backpressure: src_valid && !src_ready holds all src_* stable, and granted snk_ready is 0.
- Reset mid-packet: the packet is truncated at the output. Downstream recovery is the extender's responsibility. After release, the arbiter starts fresh with rr_ptr=0.
- No candidates: stay in IDLE, src_valid falls once the register drains.

Decomposition:
- Package ast_we_arb_pkg holds:
  - state_t enum {IDLE, PKT}
  - localparam IDX_W = $clog2(NUM_SRC), passed through a parameterized function
  - function rr_next(ptr, req) returning found flag and index
- One natural sub-module, ast_rr_picker: combinational rotate, priority-encode, un-rotate. Parameters NUM_SRC; inputs req, ptr; outputs found, idx.
- The top level holds the FSM, the orphan drop logic and the output register.

Test Plan:
- Sources 0 and 2 each request at once with a 3-beat packet, src_ready=1 -> source 0's beats with channel 0, one bubble, then source 2's beats with channel 2; rr_ptr=3.
- All 4 sources stream back-to-back single-beat packets for 12 packets -> grant order 0,1,2,3,0,1,... and each output beat has SOP=EOP=1.
- Source 1 sends a 4-beat packet while src_ready toggles 1,0,0,1,... -> no lost or duplicated beats, src_* stable while stalled, empty is passed through on EOP.
- Source 3 presents valid with sop=0 in IDLE -> the beat is dropped, err_orphan pulses for 1 cycle, and nothing appears at the output.
- src_en=4'b1011 with source 2 requesting -> source 2 is never granted. Clearing src_en[1] mid-packet -> that packet completes intact.
- arst_n asserted during beat 2 of a 5-beat packet -> all outputs 0 immediately. After release, a new request from source 1 is granted with rr_ptr starting at 0.
